// File: rtl/instruction_decoder_queue.sv
// Four-entry instruction queue that presents a one-hot decode of the head code.
// Define ILLEGAL_CODE_TRAP_EN to drop codes 8-15 at the input and raise a sticky err flag.
module instruction_decoder_queue (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_code,
  input  logic [2:0] in_sel,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_instruction,
  output logic [2:0] out_select,
  output logic [2:0] count,
  output logic [7:0] issued_cnt,
  output logic       err
);

  logic [6:0] mem [4];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic       push;
  logic       enq;
  logic       pop;
  logic [3:0] head_code;
  logic [2:0] head_sel;

  function automatic logic [7:0] decode_onehot(input logic [3:0] code);
    decode_onehot = 8'h00;
    if (!code[3]) decode_onehot[code[2:0]] = 1'b1;
  endfunction

  // No bypass: a full queue refuses input even when the head leaves this cycle.
  assign in_ready  = (count != 3'd4);
  assign out_valid = (count != 3'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

`ifdef ILLEGAL_CODE_TRAP_EN
  assign enq = push && !in_code[3];

  always_ff @(posedge clk) begin
    if (rst)
      err <= 1'b0;
    else if (push && in_code[3])
      err <= 1'b1;
  end
`else
  assign enq = push;
  assign err = 1'b0;
`endif

  assign {head_code, head_sel} = mem[rd_ptr];
  assign out_instruction = out_valid ? decode_onehot(head_code) : 8'h00;
  assign out_select      = out_valid ? head_sel : 3'd0;

  // Storage holds data only; validity is tracked entirely by count and the pointers.
  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr] <= {in_code, in_sel};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= 2'd0;
      rd_ptr     <= 2'd0;
      count      <= 3'd0;
      issued_cnt <= 8'd0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 2'd1;
      if (pop) begin
        rd_ptr     <= rd_ptr + 2'd1;
        issued_cnt <= issued_cnt + 8'd1;
      end
      case ({enq, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_decoder_queue.sv
// Directed bench for instruction_decoder_queue: a reference queue collects every accepted
// pair and is compared against the DUT head each time a pop handshake happens.
module tb_instruction_decoder_queue;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_code;
  logic [2:0] in_sel;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_instruction;
  logic [2:0] out_select;
  logic [2:0] count;
  logic [7:0] issued_cnt;
  logic       err;

  int passed = 0;
  int total  = 0;
  logic [10:0] sb_q [$];

  instruction_decoder_queue dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code), .in_sel(in_sel),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instruction(out_instruction), .out_select(out_select),
    .count(count), .issued_cnt(issued_cnt), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Scoreboard: compare on pop handshakes, then record accepted pairs.
  always @(negedge clk) begin
    logic [7:0]  e;
    logic [10:0] head;
    if (rst) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_underflow", 32'(out_instruction), 32'hFFFF);
        end else begin
          head = sb_q.pop_front();
          check("sb_instruction", 32'(out_instruction), 32'(head[10:3]));
          check("sb_select", 32'(out_select), 32'(head[2:0]));
        end
      end
      if (in_valid && in_ready) begin
        e = 8'h00;
        if (in_code < 4'd8) e[in_code[2:0]] = 1'b1;
`ifdef ILLEGAL_CODE_TRAP_EN
        if (in_code < 4'd8) sb_q.push_back({e, in_sel});
`else
        sb_q.push_back({e, in_sel});
`endif
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_code = 4'd0; in_sel = 3'd0; out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_instruction", 32'(out_instruction), 32'h00);
    check("rst_out_select", 32'(out_select), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_issued", 32'(issued_cnt), 32'd0);
    check("rst_err", 32'(err), 32'd0);

    // Single push, one-cycle latency.
    in_valid = 1'b1; in_code = 4'd5; in_sel = 3'd2;
    tick();
    in_valid = 1'b0;
    check("lat_out_valid", 32'(out_valid), 32'd1);
    check("lat_out_instruction", 32'(out_instruction), 32'h20);
    check("lat_out_select", 32'(out_select), 32'd2);
    check("lat_count", 32'(count), 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("lat_drain_count", 32'(count), 32'd0);

    // Fill to four, refuse while full, drain in order.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_code = 4'(i); in_sel = 3'(i);
      tick();
    end
    in_valid = 1'b0;
    check("full_count", 32'(count), 32'd4);
    check("full_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1; in_code = 4'd7; in_sel = 3'd7;
    tick();
    check("full_push_ignored", 32'(count), 32'd4);
    out_ready = 1'b1;
    #1;
    check("full_no_bypass", 32'(in_ready), 32'd0);
    check("full_head", 32'(out_instruction), 32'h01);
    tick();
    in_valid = 1'b0;
    check("drain1_head", 32'(out_instruction), 32'h02);
    tick();
    check("drain2_head", 32'(out_instruction), 32'h04);
    tick();
    check("drain3_head", 32'(out_instruction), 32'h08);
    tick();
    out_ready = 1'b0;
    check("drain_count", 32'(count), 32'd0);
    check("drain_issued", 32'(issued_cnt), 32'd4);
    check("drain_out_instruction", 32'(out_instruction), 32'h00);

    // Streaming at occupancy 2 across pointer wrap.
    in_valid = 1'b1; in_code = 4'd6; in_sel = 3'd1;
    tick();
    in_code = 4'd7; in_sel = 3'd3;
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_code = 4'(i % 8); in_sel = 3'(i % 5);
      tick();
      check("stream_count", 32'(count), 32'd2);
    end
    in_valid = 1'b0;
    tick();
    tick();
    out_ready = 1'b0;
    check("stream_empty", 32'(count), 32'd0);
    check("stream_issued", 32'(issued_cnt), 32'd16);

    // Illegal code handling.
    in_valid = 1'b1; in_code = 4'd9; in_sel = 3'd5;
    tick();
    in_valid = 1'b0;
`ifdef ILLEGAL_CODE_TRAP_EN
    check("trap_count", 32'(count), 32'd0);
    check("trap_err", 32'(err), 32'd1);
    check("trap_in_ready", 32'(in_ready), 32'd1);
    tick();
    check("trap_err_sticky", 32'(err), 32'd1);
`else
    check("illegal_out_valid", 32'(out_valid), 32'd1);
    check("illegal_out_instruction", 32'(out_instruction), 32'h00);
    check("illegal_out_select", 32'(out_select), 32'd5);
    check("illegal_err", 32'(err), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("illegal_issued", 32'(issued_cnt), 32'd17);
`endif

    // Reset with entries present and a handshake pending.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_code = 4'(i + 1); in_sel = 3'(i);
      tick();
    end
    check("prerst_count", 32'(count), 32'd3);
    rst = 1'b1; in_code = 4'd4; out_ready = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    check("midrst_count", 32'(count), 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_issued", 32'(issued_cnt), 32'd0);
    check("midrst_err", 32'(err), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_instruction", 32'(out_instruction), 32'h00);
    tick();
    tick();
    check("midrst_no_stale", 32'(out_valid), 32'd0);
    out_ready = 1'b0;
    in_valid = 1'b1; in_code = 4'd3; in_sel = 3'd1;
    tick();
    in_valid = 1'b0;
    check("postrst_head", 32'(out_instruction), 32'h08);
    check("postrst_count", 32'(count), 32'd1);

    // 256 pops wrap issued_cnt.
    do_reset();
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      in_code = 4'($urandom_range(0, 7)); in_sel = 3'($urandom_range(0, 7));
      tick();
    end
    check("wrap_issued_255", 32'(issued_cnt), 32'd255);
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    check("wrap_issued_0", 32'(issued_cnt), 32'd0);
    check("wrap_count", 32'(count), 32'd0);
    check("sb_leftover", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
